// File: rtl/updown_cmd_pkg.sv
// Shared encodings for the up/down command generator: FSM states and the
// latched press direction.
package updown_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_REPEAT  = 2'd2,
    ST_BLOCKED = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer for one raw
// push-button. db_next is the value db takes at the coming edge; the FSM uses
// it so that a release cancels any pulse due on the same edge.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic db,
  output logic db_next
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          flip;

  // The debounced level flips on the cycle the disagreement run reaches its limit.
  assign flip    = (sync2 != db) && (cnt == CNT_LAST);
  assign db_next = flip ? ~db : db;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; any agreement or a flip restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      db <= db_next;
      if ((sync2 == db) || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_cmd_gen.sv
// Turns two debounced push-buttons into single-cycle increment/decrement
// command pulses with auto-repeat. Pressing the opposite button while one is
// held blocks all pulses until both buttons are released.
module updown_cmd_gen
  import updown_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_up,
  input  logic btn_down,
  output logic increment,
  output logic decrement
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE - 1);

  logic          db_up;
  logic          db_up_next;
  logic          db_dn;
  logic          db_dn_next;
  state_t        state;
  dir_t          dir;
  logic [TW-1:0] timer;
  logic          other_db;
  logic          held_next;

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_up),
    .db      (db_up),
    .db_next (db_up_next)
  );

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_down),
    .db      (db_dn),
    .db_next (db_dn_next)
  );

  // Level of the button not being held, and the held button's upcoming level.
  assign other_db  = (dir == DIR_UP) ? db_dn : db_up;
  assign held_next = (dir == DIR_UP) ? db_up_next : db_dn_next;

  // Press/repeat FSM with registered, self-clearing command pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      dir       <= DIR_UP;
      timer     <= '0;
      increment <= 1'b0;
      decrement <= 1'b0;
    end else begin
      increment <= 1'b0;
      decrement <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (db_up && db_dn) begin
            state <= ST_BLOCKED;
          end else if (db_up || db_dn) begin
            increment <= db_up;
            decrement <= db_dn;
            dir       <= db_dn ? DIR_DOWN : DIR_UP;
            timer     <= DELAY_LOAD;
            state     <= ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (other_db) begin
            state <= ST_BLOCKED;
          end else if (!held_next) begin
            state <= ST_IDLE;
          end else if (timer == '0) begin
            increment <= (dir == DIR_UP);
            decrement <= (dir == DIR_DOWN);
            timer     <= RATE_LOAD;
            state     <= ST_REPEAT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_BLOCKED: begin
          if (!db_up && !db_dn) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updown_cmd_gen.sv
// Bench for updown_cmd_gen: directed scenarios with literal pulse schedules,
// then random button activity, all checked cycle by cycle against a
// behavioural model built from raw-sample windows and absolute due times.
module tb_updown_cmd_gen;

  localparam int D  = 4;
  localparam int RD = 16;
  localparam int RR = 4;

  // ---------------- clock / reset ----------------
  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic btn_up   = 1'b0;
  logic btn_down = 1'b0;
  logic increment;
  logic decrement;

  always #5 clk = ~clk;

  updown_cmd_gen #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .increment (increment),
    .decrement (decrement)
  );

  // ---------------- behavioural model ----------------
  // Raw samples per edge; the synchronised value seen at an edge is the raw
  // sample from two edges earlier. db flips when the last D synchronised
  // values all disagree with it.
  bit up_h[$];
  bit dn_h[$];
  bit m_db_up = 1'b0;
  bit m_db_dn = 1'b0;
  int m_mode  = 0;     // 0 idle, 1 holding one button, 2 blocked
  bit m_dir   = 1'b0;  // 1 = down
  int m_cyc   = 0;
  int m_due   = 0;
  bit exp_inc = 1'b0;
  bit exp_dec = 1'b0;

  function automatic bit window_flip(input bit h[$], input bit db);
    int n = h.size();
    for (int i = n - D - 2; i <= n - 3; i++) begin
      if (h[i] == db) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    up_h.delete();
    dn_h.delete();
    for (int i = 0; i < D + 2; i++) begin
      up_h.push_back(1'b0);
      dn_h.push_back(1'b0);
    end
    m_db_up = 1'b0;
    m_db_dn = 1'b0;
    m_mode  = 0;
    m_dir   = 1'b0;
    m_cyc   = 0;
    m_due   = 0;
    exp_inc = 1'b0;
    exp_dec = 1'b0;
  endtask

  task automatic model_step();
    bit nu;
    bit nd;
    bit other;
    bit held_new;
    up_h.push_back(btn_up);
    dn_h.push_back(btn_down);
    if (up_h.size() > D + 2) void'(up_h.pop_front());
    if (dn_h.size() > D + 2) void'(dn_h.pop_front());
    nu = window_flip(up_h, m_db_up) ? !m_db_up : m_db_up;
    nd = window_flip(dn_h, m_db_dn) ? !m_db_dn : m_db_dn;
    exp_inc = 1'b0;
    exp_dec = 1'b0;
    if (m_mode == 0) begin
      if (m_db_up && m_db_dn) begin
        m_mode = 2;
      end else if (m_db_up != m_db_dn) begin
        m_dir = m_db_dn;
        exp_inc = !m_dir;
        exp_dec = m_dir;
        m_due = m_cyc + RD;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      other    = m_dir ? m_db_up : m_db_dn;
      held_new = m_dir ? nd : nu;
      if (other) begin
        m_mode = 2;
      end else if (!held_new) begin
        m_mode = 0;
      end else if (m_cyc == m_due) begin
        exp_inc = !m_dir;
        exp_dec = m_dir;
        m_due = m_cyc + RR;
      end
    end else begin
      if (!m_db_up && !m_db_dn) m_mode = 0;
    end
    m_db_up = nu;
    m_db_dn = nd;
    m_cyc++;
  endtask

  // Model advances on the same events as the design.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  int edge_idx = 0;
  bit prev_inc = 1'b0;
  bit prev_dec = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // One cycle: wait for the falling edge, compare against the model, log pulses.
  task automatic tick();
    @(negedge clk);
    n_checks++;
    if (increment !== exp_inc) begin
      n_err++;
      $display("FAIL model_increment t=%0t dut=%b model=%b", $time, increment, exp_inc);
    end
    n_checks++;
    if (decrement !== exp_dec) begin
      n_err++;
      $display("FAIL model_decrement t=%0t dut=%b model=%b", $time, decrement, exp_dec);
    end
    n_checks++;
    if (increment === 1'b1 && decrement === 1'b1) begin
      n_err++;
      $display("FAIL both_high t=%0t increment=%b decrement=%b required not both 1", $time, increment, decrement);
    end
    n_checks++;
    if ((increment === 1'b1 && prev_inc) || (decrement === 1'b1 && prev_dec)) begin
      n_err++;
      $display("FAIL back_to_back t=%0t increment=%b decrement=%b required no repeat of previous cycle", $time, increment, decrement);
    end
    prev_inc = (increment === 1'b1);
    prev_dec = (decrement === 1'b1);
    if (increment === 1'b1) got_q.push_back(8'(edge_idx));
    if (decrement === 1'b1) got_q.push_back(8'(edge_idx) | 8'h80);
    edge_idx++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Called at a falling edge: the next rising edge is edge 0 of the scenario.
  task automatic begin_scn();
    got_q.delete();
    exp_q.delete();
    edge_idx = 0;
  endtask

  task automatic expect_pulse(input bit down, input int e);
    exp_q.push_back(down ? (8'(e) | 8'h80) : 8'(e));
  endtask

  // Compare the logged pulse schedule (bit 7 = decrement, low bits = edge).
  task automatic end_scn(input string name);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s pulse_count got=%0d required=%0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL %s pulse[%0d] got=%h required=%h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int hold_up;
  int hold_dn;

  initial begin
    // Reset held low with buttons toggling: outputs must stay low.
    for (int i = 0; i < 5; i++) begin
      btn_up   = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (increment !== 1'b0 || decrement !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold inc=%b dec=%b required 0 0", increment, decrement);
      end
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(20);

    // Short press: one increment after edge 6.
    begin_scn();
    btn_up = 1'b1;
    run(12);
    btn_up = 1'b0;
    run(30);
    expect_pulse(1'b0, 6);
    end_scn("short_press");

    // Auto-repeat on down; the pulse due after edge 46 is cancelled by release.
    begin_scn();
    btn_down = 1'b1;
    run(41);
    btn_down = 1'b0;
    run(30);
    expect_pulse(1'b1, 6);
    for (int e = 22; e <= 42; e += 4) expect_pulse(1'b1, e);
    end_scn("auto_repeat");

    // 3-cycle glitch: nothing.
    begin_scn();
    btn_up = 1'b1;
    run(3);
    btn_up = 1'b0;
    run(25);
    end_scn("glitch");

    // Bounce then steady press from edge 6: single pulse at edge 12.
    begin_scn();
    for (int i = 0; i < 3; i++) begin
      btn_up = 1'b1;
      run(1);
      btn_up = 1'b0;
      run(1);
    end
    btn_up = 1'b1;
    run(10);
    btn_up = 1'b0;
    run(30);
    expect_pulse(1'b0, 12);
    end_scn("bounce");

    // Conflict: down pressed while up is in its delay period.
    begin_scn();
    btn_up = 1'b1;
    run(10);
    btn_down = 1'b1;
    run(20);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    run(30);
    expect_pulse(1'b0, 6);
    end_scn("conflict");

    begin_scn();
    btn_down = 1'b1;
    run(10);
    btn_down = 1'b0;
    run(30);
    expect_pulse(1'b1, 6);
    end_scn("after_conflict");

    // Simultaneous press of both buttons: no pulse.
    begin_scn();
    btn_up   = 1'b1;
    btn_down = 1'b1;
    run(30);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    run(30);
    end_scn("both_pressed");

    // Reset in the middle of a repeat pulse.
    begin_scn();
    btn_down = 1'b1;
    run(31);
    expect_pulse(1'b1, 6);
    expect_pulse(1'b1, 22);
    expect_pulse(1'b1, 26);
    expect_pulse(1'b1, 30);
    end_scn("pre_reset_repeat");
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (increment !== 1'b0 || decrement !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async_drop inc=%b dec=%b required 0 0", increment, decrement);
    end
    run(2);
    reset_n = 1'b1;
    begin_scn();
    run(15);
    btn_down = 1'b0;
    run(30);
    expect_pulse(1'b1, 6);
    end_scn("after_reset_held");

    // Random button activity: short holds act as glitches, long holds repeat.
    begin_scn();
    hold_up = 0;
    hold_dn = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_up == 0) begin
        btn_up  = 1'($urandom_range(0, 1));
        hold_up = $urandom_range(1, 40);
      end
      if (hold_dn == 0) begin
        btn_down = ($urandom_range(0, 3) == 0);
        hold_dn  = $urandom_range(1, 40);
      end
      hold_up--;
      hold_dn--;
      tick();
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
    run(30);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
